// File: rtl/l_buffer_single_load.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : l_buffer_single_load                                        |
// | Purpose  : Preprocess loader. Routes one clause node per cycle to the  |
// |            selected engine and assembles 2*LIT_IDX_MAX literal         |
// |            pointers into a table handed out round-robin to engines.    |
// | Ports    : clock, reset (sync, active-high)                            |
// |            clause_in / load_clause_in  -> clause_out, clause_valid_out |
// |            ptr_in / load_ptr_in        -> ptr_out, ptr_valid_out       |
// |            load_change_engine_in (only with MULTI_ENGINE_EN)           |
// | Options  : MULTI_ENGINE_EN - enables engine selection across           |
// |            NUM_ENGINE engines; otherwise every strobe targets bit 0.   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module l_buffer_single_load #(
  parameter int LIT_IDX_MAX = 4,
  parameter int CLA_LENGTH  = 3,
  parameter int NUM_ENGINE  = 2,
  parameter int CLQ_DEPTH   = 64,
  localparam int LIT_W      = $clog2(LIT_IDX_MAX) + 1,
  localparam int PTR_W      = $clog2(CLQ_DEPTH),
  localparam int NODE_W     = CLA_LENGTH * (LIT_W + PTR_W),
  localparam int TBL_N      = 2 * LIT_IDX_MAX
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NODE_W-1:0]       clause_in,
  input  logic [PTR_W-1:0]        ptr_in,
  input  logic                    load_clause_in,
  input  logic                    load_ptr_in,
`ifdef MULTI_ENGINE_EN
  input  logic                    load_change_engine_in,
`endif
  output logic [NODE_W-1:0]       clause_out,
  output logic [NUM_ENGINE-1:0]   clause_valid_out,
  output logic [TBL_N*PTR_W-1:0]  ptr_out,
  output logic [NUM_ENGINE-1:0]   ptr_valid_out
);

  localparam int C_SEL_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int C_CNT_W = $clog2(TBL_N);

  logic [NODE_W-1:0]                r_clause;
  logic [NUM_ENGINE-1:0]            r_clause_valid;
  logic [TBL_N-1:0][PTR_W-1:0]      r_ptr;
  logic [NUM_ENGINE-1:0]            r_ptr_valid;
  logic [C_CNT_W-1:0]               r_cnt;

  logic [C_SEL_W-1:0]               w_cla_tgt;
  logic [C_SEL_W-1:0]               w_ptr_sel;
  logic                             w_last_slot;
  logic [NUM_ENGINE-1:0]            w_cla_onehot;
  logic [NUM_ENGINE-1:0]            w_ptr_onehot;

  assign w_last_slot  = (r_cnt == C_CNT_W'(TBL_N - 1));
  assign w_cla_onehot = NUM_ENGINE'(1) << w_cla_tgt;
  assign w_ptr_onehot = NUM_ENGINE'(1) << w_ptr_sel;

`ifdef MULTI_ENGINE_EN
  logic [C_SEL_W-1:0] r_cla_sel;
  logic [C_SEL_W-1:0] r_ptr_sel;

  function automatic logic [C_SEL_W-1:0] f_next_sel(input logic [C_SEL_W-1:0] i_sel);
    return (i_sel == C_SEL_W'(NUM_ENGINE - 1)) ? '0 : i_sel + C_SEL_W'(1);
  endfunction

  // A clause loaded together with an engine change already goes to the
  // new engine, so the target is derived combinationally from the request.
  assign w_cla_tgt = load_change_engine_in ? f_next_sel(r_cla_sel) : r_cla_sel;
  assign w_ptr_sel = r_ptr_sel;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cla_sel <= '0;
      r_ptr_sel <= '0;
    end else begin
      if (load_change_engine_in) begin
        r_cla_sel <= w_cla_tgt;
      end
      if (load_ptr_in && w_last_slot) begin
        r_ptr_sel <= f_next_sel(r_ptr_sel);
      end
    end
  end
`else
  // Single-engine build: both selectors are fixed at engine 0.
  assign w_cla_tgt = '0;
  assign w_ptr_sel = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clause       <= '0;
      r_clause_valid <= '0;
      r_ptr          <= '0;
      r_ptr_valid    <= '0;
      r_cnt          <= '0;
    end else begin
      // Clause path: the strobe lasts exactly one cycle per load.
      r_clause_valid <= load_clause_in ? w_cla_onehot : '0;
      if (load_clause_in) begin
        r_clause <= clause_in;
      end

      // Pointer path: slots are overwritten in place, never cleared, so the
      // table is complete in ptr_out during the cycle the strobe is high.
      r_ptr_valid <= '0;
      if (load_ptr_in) begin
        r_ptr[r_cnt] <= ptr_in;
        if (w_last_slot) begin
          r_ptr_valid <= w_ptr_onehot;
          r_cnt       <= '0;
        end else begin
          r_cnt <= r_cnt + C_CNT_W'(1);
        end
      end
    end
  end

  assign clause_out       = r_clause;
  assign clause_valid_out = r_clause_valid;
  assign ptr_out          = r_ptr;
  assign ptr_valid_out    = r_ptr_valid;

endmodule
`default_nettype wire

// File: tb/tb_l_buffer_single_load.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_l_buffer_single_load                                     |
// | Purpose  : Scoreboard testbench for l_buffer_single_load. Stimulus     |
// |            pushes expected strobes (with their due cycle) into queues; |
// |            a negedge monitor pops and compares when a strobe appears.  |
// | Options  : MULTI_ENGINE_EN - drives load_change_engine_in and expects  |
// |            round-robin engine strobes.                                 |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_l_buffer_single_load;

  localparam int NODE_W = 27;
  localparam int PTR_W  = 6;
  localparam int TBL_N  = 8;

  typedef struct {
    int                   cyc;
    logic [NODE_W-1:0]    data;
    logic [1:0]           vld;
  } cla_exp_t;

  typedef struct {
    int                     cyc;
    logic [TBL_N*PTR_W-1:0] data;
    logic [1:0]             vld;
  } ptr_exp_t;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NODE_W-1:0]       clause_in;
  logic [PTR_W-1:0]        ptr_in;
  logic                    load_clause_in;
  logic                    load_ptr_in;
  logic                    load_change_engine_in;
  logic [NODE_W-1:0]       clause_out;
  logic [1:0]              clause_valid_out;
  logic [TBL_N*PTR_W-1:0]  ptr_out;
  logic [1:0]              ptr_valid_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  cla_exp_t cq[$];
  ptr_exp_t pq[$];

  // Reference state of the loader, updated by the stimulus tasks.
  int                          m_cla_sel = 0;
  int                          m_ptr_sel = 0;
  int                          m_cnt     = 0;
  logic [TBL_N-1:0][PTR_W-1:0] m_tbl     = '0;

  l_buffer_single_load #(
    .LIT_IDX_MAX (4),
    .CLA_LENGTH  (3),
    .NUM_ENGINE  (2),
    .CLQ_DEPTH   (64)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .clause_in             (clause_in),
    .ptr_in                (ptr_in),
    .load_clause_in        (load_clause_in),
    .load_ptr_in           (load_ptr_in),
`ifdef MULTI_ENGINE_EN
    .load_change_engine_in (load_change_engine_in),
`endif
    .clause_out            (clause_out),
    .clause_valid_out      (clause_valid_out),
    .ptr_out               (ptr_out),
    .ptr_valid_out         (ptr_valid_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Node = {cla[2], cla[1], cla[0], ptr[2], ptr[1], ptr[0]}.
  function automatic logic [NODE_W-1:0] mk_node(input int l0, input int l1, input int l2,
                                                input int p);
    logic [2:0] a0, a1, a2;
    logic [5:0] pp;
    a0 = 3'(l0); a1 = 3'(l1); a2 = 3'(l2); pp = 6'(p);
    return {a2, a1, a0, pp, pp + 6'd1, pp + 6'd2};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One cycle of stimulus; inputs change 2 time units after the rising edge.
  task automatic drive(input bit lc, input logic [NODE_W-1:0] c, input bit lp,
                       input int p, input bit chg, input bit rst_i);
    reset                 = rst_i;
    load_clause_in        = lc;
    clause_in             = c;
    load_ptr_in           = lp;
    ptr_in                = PTR_W'(p);
    load_change_engine_in = chg;
    if (rst_i) begin
      m_cla_sel = 0;
      m_ptr_sel = 0;
      m_cnt     = 0;
      m_tbl     = '0;
    end else begin
`ifdef MULTI_ENGINE_EN
      if (chg) m_cla_sel = (m_cla_sel + 1) % 2;
`endif
      if (lc) cq.push_back('{cyc + 1, c, 2'(1 << m_cla_sel)});
      if (lp) begin
        m_tbl[m_cnt] = PTR_W'(p);
        if (m_cnt == TBL_N - 1) begin
          pq.push_back('{cyc + 1, m_tbl, 2'(1 << m_ptr_sel)});
          m_cnt = 0;
`ifdef MULTI_ENGINE_EN
          m_ptr_sel = (m_ptr_sel + 1) % 2;
`endif
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 0, 0);
  endtask

  // Monitor: compare strobes against the scoreboard, catch missing ones.
  always @(negedge clock) begin
    if (cq.size() > 0 && cq[0].cyc < cyc) begin
      checks++; failures++;
      $display("FAIL clause_missing: actual=none required_cycle=%0d", cq[0].cyc);
      void'(cq.pop_front());
    end
    if (clause_valid_out != 2'b00) begin
      if (cq.size() == 0) begin
        checks++; failures++;
        $display("FAIL clause_unexpected: actual=%b required=none", clause_valid_out);
      end else begin
        cla_exp_t e;
        e = cq.pop_front();
        check("clause_cycle", 64'(cyc), 64'(e.cyc));
        check("clause_out", 64'(clause_out), 64'(e.data));
        check("clause_valid", 64'(clause_valid_out), 64'(e.vld));
      end
    end
    if (pq.size() > 0 && pq[0].cyc < cyc) begin
      checks++; failures++;
      $display("FAIL ptr_missing: actual=none required_cycle=%0d", pq[0].cyc);
      void'(pq.pop_front());
    end
    if (ptr_valid_out != 2'b00) begin
      if (pq.size() == 0) begin
        checks++; failures++;
        $display("FAIL ptr_unexpected: actual=%b required=none", ptr_valid_out);
      end else begin
        ptr_exp_t e;
        e = pq.pop_front();
        check("ptr_cycle", 64'(cyc), 64'(e.cyc));
        check("ptr_out", 64'(ptr_out), 64'(e.data));
        check("ptr_valid", 64'(ptr_valid_out), 64'(e.vld));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clause_in = '0; ptr_in = '0;
    load_clause_in = 1'b0; load_ptr_in = 1'b0; load_change_engine_in = 1'b0;
    drive(0, '0, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 1);

    // Reset state and idle behaviour.
    check("rst_clause_out", 64'(clause_out), 64'd0);
    check("rst_clause_valid", 64'(clause_valid_out), 64'd0);
    check("rst_ptr_out", 64'(ptr_out), 64'd0);
    check("rst_ptr_valid", 64'(ptr_valid_out), 64'd0);
    idle(3);
    check("idle_clause_out", 64'(clause_out), 64'd0);
    check("idle_ptr_out", 64'(ptr_out), 64'd0);

    // Back-to-back clause loads on the current engine.
    drive(1, mk_node(0, 1, 2, 5), 0, 0, 0, 0);
    drive(1, mk_node(3, 0, 1, 9), 0, 0, 0, 0);
    drive(1, mk_node(2, 3, 0, 17), 0, 0, 0, 0);
    idle(1);
    check("clause_hold", 64'(clause_out), 64'(mk_node(2, 3, 0, 17)));
    // Load together with an engine change, then a bare change to wrap.
    drive(1, mk_node(1, 1, 1, 33), 0, 0, 1, 0);
    idle(1);
    drive(0, '0, 0, 0, 1, 0);
    drive(1, mk_node(3, 3, 3, 60), 0, 0, 0, 0);
    idle(2);

    // Two consecutive full tables.
    for (int k = 1; k <= 16; k++) drive(0, '0, 1, k, 0, 0);
    idle(2);

    // Gapped table with concurrent clause loads.
    for (int k = 17; k <= 24; k++) begin
      drive(k[0], mk_node(k % 4, 1, 2, k), 1, k, 0, 0);
      idle(k % 3);
    end
    idle(2);

    // Partial table, then reset in the same cycle as loads (reset wins).
    for (int k = 30; k <= 33; k++) drive(0, '0, 1, k, 0, 0);
    drive(1, mk_node(1, 2, 3, 40), 1, 50, 1, 1);
    check("midrst_ptr_out", 64'(ptr_out), 64'd0);
    check("midrst_clause_out", 64'(clause_out), 64'd0);
    for (int k = 41; k <= 48; k++) drive(0, '0, 1, k, 0, 0);
    idle(3);

    check("clause_queue_empty", 64'(cq.size()), 64'd0);
    check("ptr_queue_empty", 64'(pq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l_buffer_single_load.md
# l_buffer_single_load

Preprocess loader that sits between the host/preprocessing interface and the per-engine lookup latency buffers. It accepts one clause node per cycle and routes it to the currently selected engine. It also accepts one literal-pointer per cycle, assembles `2*LIT_IDX_MAX` pointers into one pointer table, and hands the completed table to the next engine in round-robin order. All outputs are registered strobes with a one-hot per-engine valid.

## Interface
Parameters, shared with the codebase typedefs:
- `LIT_IDX_MAX`, default 4: maximum literal index. `lit_t` is signed, `$clog2(LIT_IDX_MAX)+1` bits.
- `CLA_LENGTH`, default 3: literals per clause.
- `NUM_ENGINE`, default 2: number of downstream engines.
- `CLQ_DEPTH`, default 64: clause-queue depth. `ptr_t` is `$clog2(CLQ_DEPTH)` bits.
- `node_t`: packed struct `{cla_t cla; ptr_t [CLA_LENGTH-1:0] ptr;}`. This is 27 bits at the defaults.
- `dummy_ptr_t`: `ptr_t [2*LIT_IDX_MAX-1:0]`. This is 48 bits at the defaults.

Ports:
- `clock`, in, 1: single clock. All state changes happen on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `clause_in`, in, `node_t`: clause node to load.
- `ptr_in`, in, `ptr_t`: one pointer-table entry.
- `load_clause_in`, in, 1: `clause_in` is valid this cycle.
- `load_ptr_in`, in, 1: `ptr_in` is valid this cycle.
- `load_change_engine_in`, in, 1: advance the clause target engine. Present only when `MULTI_ENGINE_EN` is defined.
- `clause_out`, out, `node_t`: registered copy of the last loaded clause.
- `clause_valid_out`, out, `NUM_ENGINE`: one-hot strobe that names the engine receiving `clause_out`.
- `ptr_out`, out, `dummy_ptr_t`: pointer-table assembly register. Slot j holds the j-th pointer of the current table.
- `ptr_valid_out`, out, `NUM_ENGINE`: one-hot strobe, asserted when a full table is ready for that engine.

## Operation
**Clause path**
- `cla_sel` is the clause engine index register.
- The target is `cla_sel+1`, wrapping from `NUM_ENGINE-1` to 0, when `load_change_engine_in` is high. Otherwise the target is `cla_sel`.
- On an edge with `load_change_engine_in=1`, `cla_sel` updates to the target. This applies whether or not a load happens.
- On an edge with `load_clause_in=1`:
  - `clause_out` takes the value of `clause_in`.
  - `clause_valid_out` becomes one-hot of the target.
  - A clause loaded in the same cycle as an engine change therefore goes to the new engine.
- On an edge with `load_clause_in=0`, `clause_valid_out` becomes 0 and `clause_out` holds its value.

**Pointer path**
- The block keeps a pointer slot counter `cnt` (0..`2*LIT_IDX_MAX-1`) and a pointer engine index `ptr_sel`. Both are independent of the clause path.
- On an edge with `load_ptr_in=1`:
  - `ptr_out[cnt]` takes the value of `ptr_in`.
  - If `cnt` was the last slot: `ptr_valid_out` becomes one-hot of `ptr_sel`, `cnt` returns to 0, and `ptr_sel` increments, wrapping to 0.
  - Otherwise `cnt` increments and `ptr_valid_out` becomes 0.
- On an edge with `load_ptr_in=0`, `ptr_valid_out` becomes 0. `ptr_out` and `cnt` hold.
- `ptr_out` slots are not cleared between tables. The next table overwrites them slot by slot.

**General rules**
- Clause and pointer loads in the same cycle are both accepted. There is no back-pressure; every asserted load is consumed.
- `load_change_engine_in` has no effect on the pointer path.
- Assigned values are truncated to field widths. No sign or range checking is done.

## Timing
- Reset (synchronous) clears `clause_out`, `clause_valid_out`, `ptr_out`, `ptr_valid_out`, `cla_sel`, `ptr_sel` and `cnt` to 0.
- Reset has priority over every load in the same cycle. Reset in the middle of a table discards the partial table.
- Clause latency is 1 cycle: a load on edge N shows `clause_out`/`clause_valid_out` after edge N. The strobe is exactly one cycle wide per load, and back-to-back loads give back-to-back strobes.
- `ptr_valid_out` rises after the edge that captures the final slot. `ptr_out` holds the complete table during that cycle.
- `clause_valid_out` and `ptr_valid_out` are never anything other than one-hot or zero.

## Configuration
- With `MULTI_ENGINE_EN` defined:
  - The `load_change_engine_in` port exists.
  - `cla_sel` and `ptr_sel` span `NUM_ENGINE` engines as described in Operation.
- Without `MULTI_ENGINE_EN`:
  - The port is absent.
  - `cla_sel` and `ptr_sel` are held at 0.
  - All strobes assert bit 0 only; the other bits are tied to 0.

## Test plan
- Reset, then idle: all outputs are 0 after reset and stay 0 with no loads.
- Three clause loads with `cla`=(0,1,2),(3,0,1),(2,3,0) and change=0: each appears the cycle after its load with `clause_valid_out`=01.
- Next clause (1,1,1) loaded together with change=1 → `clause_valid_out`=10. A later change=1 with no load wraps `cla_sel` to 0, so the next load shows 01.
- Pointers 1..8 loaded on consecutive cycles → `ptr_out` slots 0..7 = 1..8 and `ptr_valid_out`=01 for one cycle after the 8th load. Pointers 9..16 → slots = 9..16 and `ptr_valid_out`=10.
- Gapped pointer loads (idle cycles inserted) → `cnt` holds during gaps and `ptr_valid_out` pulses only after the 8th accepted pointer.
- Reset asserted after 4 pointers, then 8 more pointers → the pulse comes after the 8th new pointer, with `ptr_valid_out`=01.
